// File: rtl/io_uart_tx_fifo_pkg.sv
// Shared IO map for the UART transmitter: decode bits, STATUS layout, TX FSM encoding.
package io_uart_tx_fifo_pkg;

  localparam int IO_UART_DAT_BIT  = 1;
  localparam int IO_UART_STAT_BIT = 2;

  localparam int ST_OVF   = 11;
  localparam int ST_BUSY  = 10;
  localparam int ST_FULL  = 9;
  localparam int ST_EMPTY = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // Clamp an occupancy value into the 4-bit STATUS count field.
  function automatic logic [3:0] sat4(input logic [31:0] v);
    return (v > 32'd15) ? 4'hF : v[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with AW+1 bit pointers; head is visible on dout without a read cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0]      wp;
  logic [AW:0]      rp;

  // Pointers differ only in the MSB when the write side has lapped the read side.
  assign full  = ((wp ^ rp) == {1'b1, {AW{1'b0}}});
  assign empty = (wp == rp);
  assign count = wp - rp;
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wp[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/io_uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter: DATA stores queue bytes, STATUS reports FIFO/overflow state.
module io_uart_tx_fifo
  import io_uart_tx_fifo_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10000000,
  parameter int BAUD_RATE   = 1000000,
  parameter int FIFO_AW     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IO_mem_addr,
  input  logic [31:0] IO_mem_wdata,
  input  logic        IO_mem_wr,
  output logic [31:0] IO_mem_rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int TW  = $clog2(DIV);

  // IO_mem_wr is a one-cycle strobe with no back-pressure: a store is always
  // accepted on the edge it is sampled; a store to a full FIFO is dropped and
  // latched in the sticky overflow flag. Reads are combinational, zero wait.

  logic [13:0] word_addr;
  logic        sel_data;
  logic        sel_stat;
  logic        unused_bits;

  assign word_addr   = IO_mem_addr[15:2];
  assign sel_data    = word_addr[IO_UART_DAT_BIT];
  assign sel_stat    = word_addr[IO_UART_STAT_BIT] & ~sel_data;
  assign unused_bits = ^{IO_mem_addr[31:16], IO_mem_addr[1:0], word_addr,
                         IO_mem_wdata[31:12], IO_mem_wdata[10:8]};

  logic             push;
  logic             pop;
  logic [7:0]       head;
  logic             full;
  logic             empty;
  logic [FIFO_AW:0] count;

  assign push = IO_mem_wr & sel_data & ~full;

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (IO_mem_wdata[7:0]),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  logic overflow;
  logic ovf_set;
  logic ovf_clr;

  assign ovf_set = IO_mem_wr & sel_data & full;
  assign ovf_clr = IO_mem_wr & sel_stat & IO_mem_wdata[ST_OVF];

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  logic [31:0] status;

  always_comb begin
    status           = '0;
    status[ST_OVF]   = overflow;
    status[ST_BUSY]  = tx_busy;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[3:0]      = sat4(32'(count));
  end

  always_comb begin
    IO_mem_rdata = '0;
    if (!sel_data && sel_stat) IO_mem_rdata = status;
  end

  tx_state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tick;
  logic          tx_d;
  logic          busy_d;

  assign tick = (timer == TW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      uart_tx <= tx_d;
      tx_busy <= busy_d;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = tick ? '0 : timer + 1'b1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        timer_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          state_n = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_n   = S_DATA;
          bit_idx_n = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_n   = shift >> 1;
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        // Chain straight into the next start bit when more bytes are queued.
        if (tick) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = ~empty | (state != S_IDLE);
  end

endmodule
